// File: rtl/sudoku_pkg.sv
// Shared types and constants for the sudoku puzzle loader and its helpers.
package sudoku_pkg;

   localparam int CELLS_PER_MAP = 81;
   localparam int DIGIT_W       = 4;
   localparam int MAX_DIGIT     = 9;

   typedef struct packed {
      logic [$clog2(CELLS_PER_MAP)-1:0] idx;
      logic [DIGIT_W-1:0]               value;
      logic                             visible;
   } cell_rec_t;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DONE
   } loader_state_t;

endpackage

// File: rtl/digit_relabel.sv
// Rotates a nonzero sudoku digit by an offset within 1..MAX_DIGIT; empty cells stay 0.
module digit_relabel
   import sudoku_pkg::*;
#(
   parameter int W = DIGIT_W
) (
   input  logic [W-1:0] v,
   input  logic [3:0]   offset,
   output logic [W-1:0] v_out
);

   int sum;

   always_comb begin
      sum   = 0;
      v_out = v;
      if (v != '0) begin
         sum   = ((int'(v) - 1 + int'(offset)) % MAX_DIGIT) + 1;
         v_out = W'(sum);
      end
   end

endmodule

// File: rtl/map_loader.sv
// Streams one selected puzzle from the packed constant tables as (idx, digit, visible) records.
// Optional digit relabelling per load is enabled by defining MAP_RELABEL_EN.
module map_loader
   import sudoku_pkg::*;
#(
   parameter  int N_LEVELS = 2,
   parameter  int N_MAPS   = 8,
   parameter  int CELLS    = CELLS_PER_MAP,
   parameter  int DIGIT_W  = 4,
   localparam int LW       = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1,
   localparam int MW       = (N_MAPS > 1) ? $clog2(N_MAPS) : 1,
   localparam int IW       = (CELLS > 1) ? $clog2(CELLS) : 1
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [N_LEVELS*N_MAPS*CELLS*DIGIT_W-1:0] maps_in,
   input  logic [N_LEVELS*N_MAPS*CELLS-1:0]       vis_in,
   input  logic                                   start,
   input  logic                                   abort,
   input  logic [LW-1:0]                          level,
   input  logic [MW-1:0]                          map_sel,
   output logic                                   busy,
   output logic                                   cell_valid,
   input  logic                                   cell_ready,
   output logic [IW-1:0]                          cell_idx,
   output logic [DIGIT_W-1:0]                     cell_value,
   output logic                                   cell_visible,
   output logic                                   done
);

   localparam int            TOTAL    = N_LEVELS * N_MAPS;
   localparam int            KW       = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(CELLS - 1);

   loader_state_t      state, next_state;
   logic [KW-1:0]      slice_q;
   logic [IW-1:0]      idx_q;
   logic [DIGIT_W-1:0] value_q, raw_digit, fetch_value;
   logic               vis_q, raw_vis;
   logic               accept, advance, load;
   int                 start_k, fetch_k, fetch_i, pos;

   assign accept  = (state == IDLE) && start;
   assign advance = (state == STREAM) && !abort && cell_ready;
   assign load    = accept || (advance && (idx_q != LAST_IDX));

   // The next record is fetched from the tables only when it is about to be presented,
   // so table changes affect just the records not yet shown.
   always_comb begin
      start_k = ((int'(level) < N_LEVELS) ? int'(level) : 0) * N_MAPS
              + ((int'(map_sel) < N_MAPS) ? int'(map_sel) : 0);
      fetch_k = accept ? start_k : int'(slice_q);
      fetch_i = accept ? 0 : int'(idx_q) + 1;
      pos     = TOTAL * CELLS - 1 - (fetch_k * CELLS + fetch_i);
   end

   assign raw_digit = DIGIT_W'(maps_in >> (pos * DIGIT_W));
   assign raw_vis   = 1'(vis_in >> pos);

`ifdef MAP_RELABEL_EN
   logic [3:0] cnt_q, offset_q, fetch_off;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         offset_q <= '0;
      end else begin
         cnt_q <= (cnt_q == 4'(MAX_DIGIT - 1)) ? 4'd0 : cnt_q + 4'd1;
         if (accept) offset_q <= cnt_q;
      end
   end

   // The first record is fetched in the same cycle the offset is captured.
   assign fetch_off = accept ? cnt_q : offset_q;

   digit_relabel #(
      .W(DIGIT_W)
   ) u_relabel (
      .v      (raw_digit),
      .offset (fetch_off),
      .v_out  (fetch_value)
   );
`else
   assign fetch_value = raw_digit;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) next_state = STREAM;
         end
         STREAM: begin
            if (abort)                                   next_state = IDLE;
            else if (cell_ready && (idx_q == LAST_IDX))  next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slice_q <= '0;
         idx_q   <= '0;
         value_q <= '0;
         vis_q   <= 1'b0;
      end else begin
         if (accept) slice_q <= KW'(start_k);
         if (load) begin
            idx_q   <= IW'(fetch_i);
            value_q <= fetch_value;
            vis_q   <= raw_vis;
         end
      end
   end

   assign busy         = (state != IDLE);
   assign cell_valid   = (state == STREAM);
   assign done         = (state == DONE);
   assign cell_idx     = idx_q;
   assign cell_value   = value_q;
   assign cell_visible = vis_q;

endmodule

// File: tb/tb_map_loader.sv
// Randomised self-checking bench for map_loader against an array model of the puzzle tables.
module tb_map_loader;

   localparam int NL = 2;
   localparam int NM = 8;
   localparam int NC = 81;
   localparam int DW = 4;
   localparam int AT = NL * NM;
   localparam int BL = 3;
   localparam int BM = 4;
   localparam int BT = BL * BM;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int edge_cnt;

   logic [AT*NC*DW-1:0] maps_a;
   logic [AT*NC-1:0]    vis_a_bus;
   logic                start, abort, cell_ready;
   logic [0:0]          level;
   logic [2:0]          map_sel;
   logic                busy, cell_valid, cell_visible, done;
   logic [6:0]          cell_idx;
   logic [3:0]          cell_value;

   logic [BT*NC*DW-1:0] maps_b;
   logic [BT*NC-1:0]    vis_b_bus;
   logic                start_b, abort_b, ready_b;
   logic [1:0]          level_b, map_b;
   logic                busy_b, valid_b, visible_b, done_b;
   logic [6:0]          idx_b;
   logic [3:0]          value_b;

   logic [3:0] mem_a [AT][NC];
   logic       vis_a [AT][NC];
   logic [3:0] mem_b [BT][NC];
   logic       vis_b [BT][NC];

   map_loader dut (
      .clk(clk), .reset(reset), .maps_in(maps_a), .vis_in(vis_a_bus),
      .start(start), .abort(abort), .level(level), .map_sel(map_sel),
      .busy(busy), .cell_valid(cell_valid), .cell_ready(cell_ready),
      .cell_idx(cell_idx), .cell_value(cell_value), .cell_visible(cell_visible),
      .done(done)
   );

   map_loader #(.N_LEVELS(BL), .N_MAPS(BM)) dut_b (
      .clk(clk), .reset(reset), .maps_in(maps_b), .vis_in(vis_b_bus),
      .start(start_b), .abort(abort_b), .level(level_b), .map_sel(map_b),
      .busy(busy_b), .cell_valid(valid_b), .cell_ready(ready_b),
      .cell_idx(idx_b), .cell_value(value_b), .cell_visible(visible_b),
      .done(done_b)
   );

`ifdef MAP_RELABEL_EN
   logic [3:0] rl_v, rl_out;
   digit_relabel #(.W(4)) u_rl (.v(rl_v), .offset(4'd8), .v_out(rl_out));
`endif

   // Clock edges since reset release; the relabel counter value is this modulo 9.
   always @(posedge clk or posedge reset) begin
      if (reset) edge_cnt <= 0;
      else       edge_cnt <= edge_cnt + 1;
   end

   function automatic int cur_offset();
`ifdef MAP_RELABEL_EN
      return edge_cnt % 9;
`else
      return 0;
`endif
   endfunction

   function automatic logic [3:0] exp_digit(input logic [3:0] v, input int off);
      if (v == 4'd0) return 4'd0;
      return 4'(((int'(v) - 1 + off) % 9) + 1);
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // mode 0: run to completion; mode 1: abort at stop_idx; mode 2: async reset at stop_idx
   task automatic apply_stimulus(input int lvl, input int map, input bit rnd,
                                 input int mode, input int stop_idx, input bit start_abort);
      int  k, exp_idx, cyc, off;
      bit  finished;
      k         = lvl * NM + map;
      off       = cur_offset();
      level     = 1'(lvl);
      map_sel   = 3'(map);
      start     = 1'b1;
      abort     = start_abort;
      step();
      start     = 1'b0;
      abort     = 1'b0;
      exp_idx   = 0;
      cyc       = 1;
      finished  = 1'b0;
      while (!finished && cyc < 8 * NC) begin
         check_output("valid", cell_valid, 1);
         check_output("busy", busy, 1);
         check_output("done_early", done, 0);
         check_output("idx", cell_idx, exp_idx);
         check_output("value", cell_value, exp_digit(mem_a[k][exp_idx], off));
         check_output("visible", cell_visible, vis_a[k][exp_idx]);
         if (mode == 2 && exp_idx == stop_idx) begin
            cell_ready = 1'b1;
            #2 reset = 1'b1;
            #1;
            check_output("rst_busy", busy, 0);
            check_output("rst_valid", cell_valid, 0);
            check_output("rst_idx", cell_idx, 0);
            check_output("rst_value", cell_value, 0);
            check_output("rst_visible", cell_visible, 0);
            check_output("rst_done", done, 0);
            #1 reset = 1'b0;
            step();
            finished = 1'b1;
         end else begin
            cell_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd) begin
               start   = 1'($urandom_range(0, 1));
               level   = 1'($urandom_range(0, 1));
               map_sel = 3'($urandom_range(0, 7));
            end
            abort = (mode == 1 && exp_idx == stop_idx);
            if (abort) cell_ready = 1'b1;
            step();
            start = 1'b0;
            cyc++;
            if (abort) begin
               abort = 1'b0;
               check_output("abort_busy", busy, 0);
               check_output("abort_valid", cell_valid, 0);
               check_output("abort_done", done, 0);
               finished = 1'b1;
            end else if (cell_ready) begin
               exp_idx++;
               if (exp_idx == NC) begin
                  check_output("done_pulse", done, 1);
                  check_output("done_busy", busy, 1);
                  check_output("done_valid", cell_valid, 0);
                  if (!rnd) check_output("done_cycle", cyc, NC + 1);
                  step();
                  check_output("done_clear", done, 0);
                  check_output("idle_busy", busy, 0);
                  finished = 1'b1;
               end
            end
         end
      end
      check_output("timeout", finished, 1);
      cell_ready = 1'b0;
   endtask

   task automatic stream_b(input int lvl, input int map, input int k);
      int off;
      off     = cur_offset();
      level_b = 2'(lvl);
      map_b   = 2'(map);
      start_b = 1'b1;
      ready_b = 1'b1;
      step();
      start_b = 1'b0;
      for (int i = 0; i < NC; i++) begin
         check_output("b_valid", valid_b, 1);
         check_output("b_idx", idx_b, i);
         check_output("b_value", value_b, exp_digit(mem_b[k][i], off));
         check_output("b_visible", visible_b, vis_b[k][i]);
         step();
      end
      check_output("b_done", done_b, 1);
      step();
      check_output("b_idle", busy_b, 0);
      ready_b = 1'b0;
   endtask

   initial begin
      logic [AT*NC*DW-1:0] tmp_a;
      logic [AT*NC-1:0]    tv_a;
      logic [BT*NC*DW-1:0] tmp_b;
      logic [BT*NC-1:0]    tv_b;
      int p;

      start = 0; abort = 0; cell_ready = 0; level = '0; map_sel = '0;
      start_b = 0; abort_b = 0; ready_b = 0; level_b = '0; map_b = '0;
      maps_a = '0; vis_a_bus = '0; maps_b = '0; vis_b_bus = '0;

      for (int k = 0; k < AT; k++)
         for (int c = 0; c < NC; c++) begin
            mem_a[k][c] = 4'($urandom_range(0, 9));
            vis_a[k][c] = 1'($urandom_range(0, 1));
         end
      mem_a[11][0] = 4'd1; mem_a[11][1] = 4'd9; mem_a[11][2] = 4'd0;
      for (int k = 0; k < BT; k++)
         for (int c = 0; c < NC; c++) begin
            mem_b[k][c] = 4'($urandom_range(0, 9));
            vis_b[k][c] = 1'($urandom_range(0, 1));
         end

      // Slice 0 at the MSB end; within a slice cell 0 is the most-significant field.
      for (int k = 0; k < AT; k++)
         for (int c = 0; c < NC; c++) begin
            p = AT * NC - 1 - (k * NC + c);
            tmp_a = '0; tmp_a[3:0] = mem_a[k][c];
            tv_a  = '0; tv_a[0]    = vis_a[k][c];
            maps_a    = maps_a | (tmp_a << (p * DW));
            vis_a_bus = vis_a_bus | (tv_a << p);
         end
      for (int k = 0; k < BT; k++)
         for (int c = 0; c < NC; c++) begin
            p = BT * NC - 1 - (k * NC + c);
            tmp_b = '0; tmp_b[3:0] = mem_b[k][c];
            tv_b  = '0; tv_b[0]    = vis_b[k][c];
            maps_b    = maps_b | (tmp_b << (p * DW));
            vis_b_bus = vis_b_bus | (tv_b << p);
         end

      #12;
      check_output("reset_busy", busy, 0);
      check_output("reset_valid", cell_valid, 0);
      check_output("reset_idx", cell_idx, 0);
      check_output("reset_value", cell_value, 0);
      check_output("reset_visible", cell_visible, 0);
      check_output("reset_done", done, 0);
      check_output("reset_b_valid", valid_b, 0);
      @(negedge clk);
      reset = 1'b0;
      step();

      $display("[TB] full stream level 1 map 3");
      apply_stimulus(1, 3, 1'b0, 0, 0, 1'b0);
      $display("[TB] random back-pressure");
      apply_stimulus(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'b1, 0, 0, 1'b0);
      $display("[TB] abort at idx 40, then restart with start and abort together");
      apply_stimulus(0, 5, 1'b0, 1, 40, 1'b0);
      apply_stimulus(0, 5, 1'b0, 0, 0, 1'b1);
      $display("[TB] reset at idx 20, then clean reload");
      apply_stimulus(1, 0, 1'b0, 2, 20, 1'b0);
      apply_stimulus(1, 7, 1'b0, 0, 0, 1'b0);

`ifdef MAP_RELABEL_EN
      $display("[TB] relabel with offset 8");
      while (edge_cnt % 9 != 8) step();
      apply_stimulus(1, 3, 1'b0, 0, 0, 1'b0);
      rl_v = 4'd1; #1; check_output("rl_1", rl_out, 9);
      rl_v = 4'd9; #1; check_output("rl_9", rl_out, 8);
      rl_v = 4'd0; #1; check_output("rl_0", rl_out, 0);
      step();
`endif

      $display("[TB] parameter sweep 3 levels x 4 maps");
      stream_b(2, 3, 11);
      stream_b(3, 1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
